// File: rtl/mem_access_unit.sv
// Load/store unit between the exec stage and a single-beat request/ack bus.
// Accepts one aligned access at a time, stalls exec via hold, drives
// lane-replicated store data with byte strobes, and extends load results.
module mem_access_unit (
  input  logic        clk,
  input  logic        rstN,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic        loadUnsigned,
  input  logic [31:0] addr,
  input  logic [31:0] memDin,
  output logic        hold,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busWstrb,
  output logic [31:0] busWdata,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        fault
);

  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  // 2'b11 is unused and falls back to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic        is_req;
  logic        aligned;
  logic        legal;
  logic        accept;
  logic        reject;

  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  logic        is_load_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;

  logic [31:0] bus_addr_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] bus_wdata_q;
  logic        bus_we_q;
  logic [31:0] load_data_q;
  logic [31:0] load_ext;
  logic [31:0] rd_shift;
  logic        fault_q;

  // Request decode: size legality and natural alignment.
  always_comb begin
    is_req  = (memOp == OpLoad) || (memOp == OpStore);
    aligned = 1'b0;
    legal   = 1'b1;
    case (memSize)
      SzByte:  aligned = 1'b1;
      SzHalf:  aligned = ~addr[0];
      SzWord:  aligned = (addr[1:0] == 2'b00);
      default: legal   = 1'b0;
    endcase
    accept = (state_q == StIdle) && is_req && legal && aligned;
    reject = (state_q == StIdle) && is_req && !(legal && aligned);
  end

  // Store lane replication and byte strobes; loads never write.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = memDin;
    if (memOp == OpStore) begin
      case (memSize)
        SzByte: begin
          wstrb_d = 4'b0001 << addr[1:0];
          wdata_d = {4{memDin[7:0]}};
        end
        SzHalf: begin
          wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{memDin[15:0]}};
        end
        SzWord: begin
          wstrb_d = 4'b1111;
          wdata_d = memDin;
        end
        default: begin
          wstrb_d = 4'b0000;
          wdata_d = memDin;
        end
      endcase
    end
  end

  // Next-state logic and combinational stall/handshake outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait:  if (busAck) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // hold is gated by rstN so exec is never stalled while the unit is in reset.
  assign hold      = rstN && (accept || ((state_q == StWait) && !busAck));
  assign busReq    = (state_q == StWait);
  assign loadValid = (state_q == StDone) && is_load_q;

  // Select the addressed lane(s) of the read word and extend.
  always_comb begin
    rd_shift = busRdata >> {addr_lo_q, 3'b000};
    load_ext = busRdata;
    case (size_q)
      SzByte:  load_ext = unsigned_q ? {24'b0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SzHalf:  load_ext = unsigned_q ? {16'b0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = busRdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request at accept; bus outputs then stay stable through WAIT.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      is_load_q   <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_lo_q   <= 2'b00;
      bus_addr_q  <= 32'h0;
      bus_wstrb_q <= 4'h0;
      bus_wdata_q <= 32'h0;
      bus_we_q    <= 1'b0;
    end else if (accept) begin
      is_load_q   <= (memOp == OpLoad);
      size_q      <= memSize;
      unsigned_q  <= loadUnsigned;
      addr_lo_q   <= addr[1:0];
      bus_addr_q  <= {addr[31:2], 2'b00};
      bus_wstrb_q <= wstrb_d;
      bus_wdata_q <= wdata_d;
      bus_we_q    <= (memOp == OpStore);
    end
  end

  // Load result register and one-cycle fault pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      load_data_q <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      fault_q <= reject;
      if ((state_q == StWait) && busAck && is_load_q) begin
        load_data_q <= load_ext;
      end
    end
  end

  assign busAddr  = bus_addr_q;
  assign busWstrb = bus_wstrb_q;
  assign busWdata = bus_wdata_q;
  assign busWe    = bus_we_q;
  assign loadData = load_data_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;

  logic        clk;
  logic        rstN;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic        loadUnsigned;
  logic [31:0] addr;
  logic [31:0] memDin;
  logic        hold;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busWstrb;
  logic [31:0] busWdata;
  logic [31:0] busRdata;
  logic        busAck;
  logic [31:0] loadData;
  logic        loadValid;
  logic        fault;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_ld = 32'h0;

  mem_access_unit dut (
    .clk          (clk),
    .rstN         (rstN),
    .memOp        (memOp),
    .memSize      (memSize),
    .loadUnsigned (loadUnsigned),
    .addr         (addr),
    .memDin       (memDin),
    .hold         (hold),
    .busReq       (busReq),
    .busWe        (busWe),
    .busAddr      (busAddr),
    .busWstrb     (busWstrb),
    .busWdata     (busWdata),
    .busRdata     (busRdata),
    .busAck       (busAck),
    .loadData     (loadData),
    .loadValid    (loadValid),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: extract and extend a load result from a read word.
  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v;
    int lane;
    lane = int'(a % 4);
    if (size == 2'd0) begin
      v = (rdata >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (rdata >> (8 * lane)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // One access starting at a falling edge with the unit idle. delay = number
  // of WAIT cycles before ack. junk presents a legal load plus a stray ack in DONE.
  task automatic txn(input logic [1:0] op, input logic [1:0] size, input logic uns,
                     input logic [31:0] a, input logic [31:0] din, input logic [31:0] rdata,
                     input int delay, input bit junk);
    bit is_req, ok, is_load;
    int nbytes;
    logic [31:0] e_strb, e_wdata;
    check_eq("idle_busreq", {31'b0, busReq}, 32'd0);
    check_eq("idle_lvalid", {31'b0, loadValid}, 32'd0);
    memOp = op; memSize = size; loadUnsigned = uns; addr = a; memDin = din; busAck = 1'b0;
    is_req  = (op == 2'd1) || (op == 2'd2);
    is_load = (op == 2'd1);
    nbytes  = 1 << size;
    ok      = is_req && (size != 2'd3) && ((a % nbytes) == 0);
    #1;
    check_eq("accept_hold", {31'b0, hold}, {31'b0, ok});
    if (!ok) begin
      @(negedge clk);
      check_eq("fault", {31'b0, fault}, {31'b0, is_req});
      check_eq("rej_busreq", {31'b0, busReq}, 32'd0);
      check_eq("rej_hold", {31'b0, hold}, 32'd0);
      memOp = 2'd0;
      @(negedge clk);
      check_eq("fault_pulse", {31'b0, fault}, 32'd0);
      check_eq("rej_busreq2", {31'b0, busReq}, 32'd0);
      return;
    end
    e_strb  = 32'd0;
    e_wdata = din;
    if (!is_load) begin
      if (size == 2'd0) begin
        e_strb = 32'd1 << (a % 4);  e_wdata = (din & 32'hFF) * 32'h01010101;
      end else if (size == 2'd1) begin
        e_strb = 32'd3 << (a % 4);  e_wdata = (din & 32'hFFFF) * 32'h00010001;
      end else begin
        e_strb = 32'hF;
      end
    end
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      check_eq("wait_busreq", {31'b0, busReq}, 32'd1);
      check_eq("bus_addr", busAddr, a & ~32'd3);
      check_eq("bus_we", {31'b0, busWe}, {31'b0, !is_load});
      check_eq("bus_wstrb", {28'b0, busWstrb}, e_strb);
      if (!is_load) check_eq("bus_wdata", busWdata, e_wdata);
      if (c == delay) begin
        busAck = 1'b1; busRdata = rdata;
        #1 check_eq("ack_hold", {31'b0, hold}, 32'd0);
      end else begin
        busRdata = $urandom;
        #1 check_eq("wait_hold", {31'b0, hold}, 32'd1);
      end
    end
    @(negedge clk);
    if (is_load) exp_ld = ref_load(size, uns, a, rdata);
    busAck = 1'b0;
    if (junk) begin
      memOp = 2'd1; memSize = 2'd2; addr = $urandom & ~32'd3; busAck = 1'b1;
    end else begin
      memOp = 2'd0;
    end
    check_eq("done_lvalid", {31'b0, loadValid}, {31'b0, is_load});
    check_eq("done_ldata", loadData, exp_ld);
    check_eq("done_busreq", {31'b0, busReq}, 32'd0);
    #1 check_eq("done_hold", {31'b0, hold}, 32'd0);
    @(negedge clk);
    memOp = 2'd0; busAck = 1'b0;
    check_eq("post_lvalid", {31'b0, loadValid}, 32'd0);
    check_eq("post_ldata", loadData, exp_ld);
    check_eq("post_fault", {31'b0, fault}, 32'd0);
  endtask

  initial begin
    rstN = 1'b0; memOp = 2'd0; memSize = 2'd0; loadUnsigned = 1'b0;
    addr = 32'h0; memDin = 32'h0; busRdata = 32'h0; busAck = 1'b0;
    @(negedge clk);
    memOp = 2'd2; memSize = 2'd2; addr = 32'h100;
    #1;
    check_eq("rst_hold", {31'b0, hold}, 32'd0);
    check_eq("rst_busreq", {31'b0, busReq}, 32'd0);
    check_eq("rst_busaddr", busAddr, 32'd0);
    check_eq("rst_wstrb", {28'b0, busWstrb}, 32'd0);
    check_eq("rst_wdata", busWdata, 32'd0);
    check_eq("rst_ldata", loadData, 32'd0);
    check_eq("rst_flags", {29'b0, busWe, loadValid, fault}, 32'd0);
    memOp = 2'd0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Directed cases.
    txn(2'd2, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    txn(2'd1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
    txn(2'd1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
    txn(2'd2, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 1, 1'b0);
    txn(2'd1, 2'd1, 1'b0, 32'h22, 32'h0, 32'hABCD0000, 0, 1'b0);
    txn(2'd1, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1'b0);
    txn(2'd1, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    txn(2'd3, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    txn(2'd0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    txn(2'd1, 2'd2, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 0, 1'b1);
    txn(2'd1, 2'd1, 1'b1, 32'h206, 32'h0, 32'h9876FFFF, 0, 1'b1);

    // Reset during WAIT abandons the transaction.
    memOp = 2'd1; memSize = 2'd2; loadUnsigned = 1'b0; addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    check_eq("rw_busreq", {31'b0, busReq}, 32'd1);
    rstN = 1'b0;
    #1;
    check_eq("rw_busreq_drop", {31'b0, busReq}, 32'd0);
    check_eq("rw_hold", {31'b0, hold}, 32'd0);
    check_eq("rw_busaddr", busAddr, 32'd0);
    exp_ld = 32'h0;
    check_eq("rw_ldata", loadData, exp_ld);
    busAck = 1'b1; busRdata = 32'h1234;
    @(negedge clk);
    check_eq("rw_lvalid", {31'b0, loadValid}, 32'd0);
    check_eq("rw_fault", {31'b0, fault}, 32'd0);
    busAck = 1'b0; memOp = 2'd0;
    rstN = 1'b1;
    @(negedge clk);
    txn(2'd1, 2'd2, 1'b0, 32'h0, 32'h0, 32'h5, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      logic [1:0] op, sz;
      logic [31:0] a;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = 2'($urandom_range(1, 2));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'd3 | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
      txn(op, sz, 1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 3)),
          1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
